// File: rtl/project_mux_pkg.sv
// Shared types and register map for the project multiplexer.
package project_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_SETTINGS = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_GUARD    = 2'd3;

    localparam int EN_BIT  = 8;
    localparam int ERR_BIT = 8;

endpackage

// File: rtl/project_mux_wb_regs.sv
// Wishbone slave: decode, single-wait-state ack, register file and
// the CTRL-write strobe that kicks off a switchover.
module project_mux_wb_regs
    import project_mux_pkg::*;
#(
    parameter int          SET_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          GUARD_RST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  state_t           state,
    input  logic [3:0]       active,
    input  logic             err,
    output logic [3:0]       sel,
    output logic             en,
    output logic [SET_W-1:0] shadow,
    output logic [7:0]       guard,
    output logic             ctrl_wr
);

    logic        hit;
    logic        acc;
    logic        wr;
    logic [1:0]  reg_a;
    logic [31:0] rdata;
    logic        unused_adr;

    assign reg_a      = wbs_adr_i[3:2];
    assign unused_adr = ^wbs_adr_i[1:0];
    assign hit        = wbs_cyc_i & wbs_stb_i
                      & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc        = hit & ~wbs_ack_o;
    assign wr         = acc & wbs_we_i;
    assign ctrl_wr    = wr & (reg_a == REG_CTRL);

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (reg_a == REG_CTRL): begin
                rdata[3:0]    = sel;
                rdata[EN_BIT] = en;
            end
            (reg_a == REG_SETTINGS): rdata = 32'(shadow);
            (reg_a == REG_STATUS): begin
                rdata[1:0]     = state;
                rdata[7:4]     = active;
                rdata[ERR_BIT] = err;
            end
            (reg_a == REG_GUARD): rdata[7:0] = guard;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            sel       <= '0;
            en        <= 1'b0;
            shadow    <= '0;
            guard     <= 8'(GUARD_RST);
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rdata : '0;
            if (wr) begin
                unique case (1'b1)
                    (reg_a == REG_CTRL): begin
                        sel <= wbs_dat_i[3:0];
                        en  <= wbs_dat_i[EN_BIT];
                    end
                    (reg_a == REG_SETTINGS): shadow <= SET_W'(wbs_dat_i);
                    (reg_a == REG_STATUS):   ;
                    (reg_a == REG_GUARD):    guard <= wbs_dat_i[7:0];
                endcase
            end
        end
    end

endmodule

// File: rtl/project_mux.sv
// Project multiplexer: guarded switchover between user slots, pad
// muxing, per-slot resets and atomically committed settings.
module project_mux
    import project_mux_pkg::*;
#(
    parameter int          NUM_SLOTS = 8,
    parameter int          IO_W      = 33,
    parameter int          SET_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          GUARD_RST = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    rst_n,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [NUM_SLOTS*IO_W-1:0] slot_do,
    input  logic [NUM_SLOTS*IO_W-1:0] slot_oeb,
    output logic [IO_W-1:0]         io_out,
    output logic [IO_W-1:0]         io_oeb,
    output logic [NUM_SLOTS-1:0]    slot_rst_n,
    output logic [SET_W-1:0]        custom_settings,
    output logic                    irq
);

    logic [3:0]       sel;
    logic             en;
    logic [SET_W-1:0] shadow;
    logic [7:0]       guard;
    logic             ctrl_wr;

    state_t                state, state_nx;
    logic [7:0]            cnt, cnt_nx;
    logic [3:0]            active, active_nx;
    logic                  err, err_nx;
    logic [SET_W-1:0]      set_nx;
    logic [NUM_SLOTS-1:0]  rst_nx;
    logic                  irq_nx;
    logic                  fits;

    project_mux_wb_regs #(
        .SET_W     (SET_W),
        .BASE_ADDR (BASE_ADDR),
        .GUARD_RST (GUARD_RST)
    ) u_regs (
        .clk       (wb_clk_i),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .state     (state),
        .active    (active),
        .err       (err),
        .sel       (sel),
        .en        (en),
        .shadow    (shadow),
        .guard     (guard),
        .ctrl_wr   (ctrl_wr)
    );

    assign fits = {28'd0, sel} < NUM_SLOTS;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        active_nx = active;
        err_nx    = err;
        set_nx    = custom_settings;
        irq_nx    = 1'b0;
        if (ctrl_wr) begin
            state_nx = ISOLATE;
            cnt_nx   = (guard == 8'd0) ? 8'd1 : guard;
            set_nx   = shadow;
            err_nx   = 1'b0;
        end else if (state == ISOLATE) begin
            if (cnt == 8'd1) begin
                if (en && fits) begin
                    state_nx  = RUN;
                    active_nx = sel;
                    irq_nx    = 1'b1;
                end else begin
                    state_nx = IDLE;
                    err_nx   = en;
                end
            end else begin
                cnt_nx = cnt - 8'd1;
            end
        end
        // resets track the next state so the slot wakes on the RUN edge
        rst_nx = (state_nx == RUN)
               ? (NUM_SLOTS'(1) << active_nx) : '0;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            active          <= '0;
            err             <= 1'b0;
            custom_settings <= '0;
            slot_rst_n      <= '0;
            irq             <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            active          <= active_nx;
            err             <= err_nx;
            custom_settings <= set_nx;
            slot_rst_n      <= rst_nx;
            irq             <= irq_nx;
        end
    end

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        if (state == RUN) begin
            io_out = slot_do[32'(active) * IO_W +: IO_W];
            io_oeb = slot_oeb[32'(active) * IO_W +: IO_W];
        end
    end

endmodule
